// File: rtl/ras_pkg.sv
// Shared types and sizing for the return-address-stack control path.
package ras_pkg;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_INDEX = 4;

  typedef enum logic {RAS_IDLE, RAS_RECOVER} ras_state_t;

  typedef struct packed {
    logic [RAS_INDEX-1:0] tos;
    logic [RAS_INDEX:0]   count;
  } ras_ptr_t;
endpackage

// File: rtl/ras_ptr_next.sv
// Next-state for one RAS pointer (tos + occupancy) given a push/pop pair.
// Purely combinational; the write index is always the post-update tos.
import ras_pkg::*;

module ras_ptr_next #(
  parameter int DEPTH = RAS_DEPTH
) (
  input  ras_ptr_t             cur_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  output ras_ptr_t             nxt_o,
  output logic [RAS_INDEX-1:0] wr_idx_o
);
  localparam logic [RAS_INDEX-1:0] TOS_ONE = 1;
  localparam logic [RAS_INDEX:0]   CNT_ONE = 1;
  localparam logic [RAS_INDEX:0]   CNT_FULL = DEPTH[RAS_INDEX:0];

  always_comb begin
    nxt_o = cur_i;
    unique case ({push_i, pop_i})
      2'b10: begin
        // Overflow wraps onto the oldest entry; occupancy just saturates.
        nxt_o.tos = cur_i.tos + TOS_ONE;
        if (cur_i.count != CNT_FULL) nxt_o.count = cur_i.count + CNT_ONE;
      end
      2'b01: begin
        if (cur_i.count != '0) begin
          nxt_o.tos   = cur_i.tos - TOS_ONE;
          nxt_o.count = cur_i.count - CNT_ONE;
        end
      end
      2'b11: begin
        if (cur_i.count == '0) nxt_o.count = CNT_ONE;
      end
      default: ;
    endcase
    wr_idx_o = nxt_o.tos;
  end
endmodule

// File: rtl/ras_ctrl.sv
// RAS pointer/control stage: speculative and architectural TOS tracking, RAM port drive,
// and flush recovery that defers the RAM restore until no retire-time push is pending.
import ras_pkg::*;

module ras_ctrl #(
  parameter int DEPTH = RAS_DEPTH,
  parameter int INDEX = RAS_INDEX,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             specPush_i,
  input  logic             specPop_i,
  input  logic [WIDTH-1:0] specPushAddr_i,
  input  logic             archPush_i,
  input  logic             archPop_i,
  input  logic [WIDTH-1:0] archPushAddr_i,
  input  logic             recoverFlag_i,
  input  logic [WIDTH-1:0] rasData_i,
  output logic [WIDTH-1:0] predRetAddr_o,
  output logic             predValid_o,
  output logic             busy_o,
  output logic [INDEX-1:0] ramRdAddr_o,
  output logic [INDEX-1:0] ramWrAddr0_o,
  output logic [WIDTH-1:0] ramWrData0_o,
  output logic             ramWe0_o,
  output logic [INDEX-1:0] ramWrAddr1_o,
  output logic [WIDTH-1:0] ramWrData1_o,
  output logic             ramWe1_o,
  output logic             ramRecover_o
);
  ras_state_t       state_q, state_d;
  ras_ptr_t         spec_q, spec_d, spec_nxt;
  ras_ptr_t         arch_q, arch_d, arch_nxt;
  logic [INDEX-1:0] spec_widx, arch_widx;
  logic             spec_en, recover;

  // Fetch-side ops only count in IDLE and not in the flush cycle itself.
  assign spec_en = (state_q == RAS_IDLE) && !recoverFlag_i;

  ras_ptr_next #(.DEPTH(DEPTH)) u_spec_next (
    .cur_i    (spec_q),
    .push_i   (specPush_i & spec_en),
    .pop_i    (specPop_i & spec_en),
    .nxt_o    (spec_nxt),
    .wr_idx_o (spec_widx)
  );

  ras_ptr_next #(.DEPTH(DEPTH)) u_arch_next (
    .cur_i    (arch_q),
    .push_i   (archPush_i),
    .pop_i    (archPop_i),
    .nxt_o    (arch_nxt),
    .wr_idx_o (arch_widx)
  );

  always_comb begin
    state_d = state_q;
    spec_d  = spec_nxt;
    arch_d  = arch_nxt;
    recover = 1'b0;
    unique case (state_q)
      RAS_IDLE: begin
        if (recoverFlag_i) state_d = RAS_RECOVER;
      end
      RAS_RECOVER: begin
        spec_d = spec_q;
        // RAM drops writes while restoring, so hold off while a retire push is present.
        if (!archPush_i) begin
          recover = !reset;
          spec_d  = arch_nxt;
          state_d = RAS_IDLE;
        end
      end
      default: state_d = RAS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RAS_IDLE;
      spec_q  <= '0;
      arch_q  <= '0;
    end else begin
      state_q <= state_d;
      spec_q  <= spec_d;
      arch_q  <= arch_d;
    end
  end

  assign predRetAddr_o = rasData_i;
  assign predValid_o   = (spec_q.count != '0);
  assign busy_o        = (state_q == RAS_RECOVER);
  assign ramRdAddr_o   = spec_q.tos;
  assign ramWrAddr0_o  = spec_widx;
  assign ramWrData0_o  = specPushAddr_i;
  assign ramWe0_o      = specPush_i & spec_en;
  assign ramWrAddr1_o  = arch_widx;
  assign ramWrData1_o  = archPushAddr_i;
  assign ramWe1_o      = archPush_i & !recover;
  assign ramRecover_o  = recover;
endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: RAM fixture, per-cycle expected outputs queued at drive time and
// popped at the falling edge, plus directed checks for the key scenarios.
module tb_ras_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        specPush_i = 0, specPop_i = 0, archPush_i = 0, archPop_i = 0, recoverFlag_i = 0;
  logic [31:0] specPushAddr_i = '0, archPushAddr_i = '0;
  logic [31:0] rasData_i, predRetAddr_o, ramWrData0_o, ramWrData1_o;
  logic        predValid_o, busy_o, ramWe0_o, ramWe1_o, ramRecover_o;
  logic [3:0]  ramRdAddr_o, ramWrAddr0_o, ramWrAddr1_o;

  int n_vec = 0;
  int n_err = 0;

  ras_ctrl dut (
    .clk(clk), .reset(reset),
    .specPush_i(specPush_i), .specPop_i(specPop_i), .specPushAddr_i(specPushAddr_i),
    .archPush_i(archPush_i), .archPop_i(archPop_i), .archPushAddr_i(archPushAddr_i),
    .recoverFlag_i(recoverFlag_i), .rasData_i(rasData_i),
    .predRetAddr_o(predRetAddr_o), .predValid_o(predValid_o), .busy_o(busy_o),
    .ramRdAddr_o(ramRdAddr_o),
    .ramWrAddr0_o(ramWrAddr0_o), .ramWrData0_o(ramWrData0_o), .ramWe0_o(ramWe0_o),
    .ramWrAddr1_o(ramWrAddr1_o), .ramWrData1_o(ramWrData1_o), .ramWe1_o(ramWe1_o),
    .ramRecover_o(ramRecover_o)
  );

  always #5 clk = ~clk;

  // RAM fixture: speculative array plus architectural checkpoint, restored on recover.
  logic [31:0] ram_spec [16];
  logic [31:0] ram_arch [16];
  assign rasData_i = ram_spec[ramRdAddr_o];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        ram_spec[i] <= '0;
        ram_arch[i] <= '0;
      end
    end else if (ramRecover_o) begin
      ram_spec <= ram_arch;
    end else begin
      if (ramWe0_o) ram_spec[ramWrAddr0_o] <= ramWrData0_o;
      if (ramWe1_o) ram_arch[ramWrAddr1_o] <= ramWrData1_o;
    end
  end

  // Reference state
  int          m_st, m_stos, m_scnt, m_atos, m_acnt;
  logic [31:0] g_spec [16];
  logic [31:0] g_arch [16];

  typedef struct {
    logic        pv, busy, rec, we0, we1;
    logic [3:0]  rd, wa0, wa1;
    logic [31:0] wd0, wd1, pra;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    m_st = 0; m_stos = 0; m_scnt = 0; m_atos = 0; m_acnt = 0;
    for (int i = 0; i < 16; i++) begin
      g_spec[i] = '0;
      g_arch[i] = '0;
    end
  endtask

  task automatic stack_next(input int tos, input int cnt, input logic pu, input logic po,
                            output int ntos, output int ncnt);
    ntos = tos;
    ncnt = cnt;
    if (pu && po) begin
      if (cnt == 0) ncnt = 1;
    end else if (pu) begin
      ntos = (tos + 1) % 16;
      ncnt = (cnt < 16) ? cnt + 1 : 16;
    end else if (po && cnt > 0) begin
      ntos = (tos + 15) % 16;
      ncnt = cnt - 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    {specPush_i, specPop_i, archPush_i, archPop_i, recoverFlag_i} = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One cycle: drive, queue expectation, compare at the falling edge, advance the model.
  task automatic step(input logic sp, input logic spo, input logic [31:0] spa,
                      input logic ap, input logic apo, input logic [31:0] apa,
                      input logic rf, input logic rst);
    exp_t e, g;
    int   sn_t, sn_c, an_t, an_c;
    logic en;
    @(posedge clk); #1;
    specPush_i = sp; specPop_i = spo; specPushAddr_i = spa;
    archPush_i = ap; archPop_i = apo; archPushAddr_i = apa;
    recoverFlag_i = rf; reset = rst;
    en = (m_st == 0) && !rf;
    stack_next(m_stos, m_scnt, sp && en, spo && en, sn_t, sn_c);
    stack_next(m_atos, m_acnt, ap, apo, an_t, an_c);
    e.pv   = (m_scnt != 0);
    e.busy = (m_st == 1);
    e.rd   = 4'(m_stos);
    e.pra  = g_spec[m_stos];
    e.we0  = sp && en;
    e.wa0  = 4'(sn_t);
    e.wd0  = spa;
    e.rec  = (m_st == 1) && !ap && !rst;
    e.we1  = ap && !e.rec;
    e.wa1  = 4'(an_t);
    e.wd1  = apa;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      g = exp_q.pop_front();
      chk("predValid", predValid_o, g.pv);
      chk("busy", busy_o, g.busy);
      chk("rdAddr", ramRdAddr_o, g.rd);
      chk("predRetAddr", predRetAddr_o, g.pra);
      chk("we0", ramWe0_o, g.we0);
      chk("we1", ramWe1_o, g.we1);
      chk("recover", ramRecover_o, g.rec);
      if (g.we0) begin
        chk("wrAddr0", ramWrAddr0_o, g.wa0);
        chk("wrData0", ramWrData0_o, g.wd0);
      end
      if (g.we1) begin
        chk("wrAddr1", ramWrAddr1_o, g.wa1);
        chk("wrData1", ramWrData1_o, g.wd1);
      end
    end
    if (rst) begin
      model_clear();
    end else begin
      if (e.rec) g_spec = g_arch;
      else begin
        if (e.we0) g_spec[sn_t] = spa;
        if (e.we1) g_arch[an_t] = apa;
      end
      if (m_st == 0) begin
        m_stos = sn_t; m_scnt = sn_c; m_st = rf ? 1 : 0;
      end else if (e.rec) begin
        m_stos = an_t; m_scnt = an_c; m_st = 0;
      end
      m_atos = an_t; m_acnt = an_c;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    do_reset();

    // Push A, B then pop B
    idle();
    chk("t1_rst_pv", predValid_o, 0);
    chk("t1_rst_rd", ramRdAddr_o, 0);
    step(1, 0, 32'h100, 0, 0, 0, 0, 0);
    chk("t1_wa0_a", ramWrAddr0_o, 1);
    step(1, 0, 32'h200, 0, 0, 0, 0, 0);
    chk("t1_wa0_b", ramWrAddr0_o, 2);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t1_pred", predRetAddr_o, 32'h200);
    chk("t1_pv", predValid_o, 1);
    idle();
    chk("t1_tos", ramRdAddr_o, 1);

    // Overflow wrap then full drain plus one underflow pop
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 0, 32'h1000 + i, 0, 0, 0, 0, 0);
    idle();
    chk("t2_tos", ramRdAddr_o, 1);
    chk("t2_ent1", predRetAddr_o, 32'h1010);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      if (i == 16) chk("t2_last_pv", predValid_o, 0);
    end
    idle();
    chk("t2_tos_end", ramRdAddr_o, 1);

    // Flush restores spec from arch
    do_reset();
    step(1, 0, 32'hA00, 1, 0, 32'h100, 0, 0);
    step(1, 0, 32'hB00, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t3_busy_flag", busy_o, 0);
    idle();
    chk("t3_rec", ramRecover_o, 1);
    chk("t3_busy", busy_o, 1);
    idle();
    chk("t3_busy_end", busy_o, 0);
    chk("t3_tos", ramRdAddr_o, 1);
    chk("t3_pred", predRetAddr_o, 32'h100);
    chk("t3_pv", predValid_o, 1);

    // Restore deferred while retire pushes keep arriving
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 32'hDEAD, 1, 0, 32'h301, 0, 0);
    chk("t4_we1_a", ramWe1_o, 1);
    chk("t4_rec_a", ramRecover_o, 0);
    step(0, 0, 0, 1, 0, 32'h302, 0, 0);
    chk("t4_we1_b", ramWe1_o, 1);
    chk("t4_rec_b", ramRecover_o, 0);
    idle();
    chk("t4_rec_c", ramRecover_o, 1);
    idle();
    chk("t4_tos", ramRdAddr_o, 2);
    chk("t4_pred", predRetAddr_o, 32'h302);
    chk("t4_busy", busy_o, 0);

    // Simultaneous push+pop at tos 3
    do_reset();
    step(1, 0, 32'h31, 0, 0, 0, 0, 0);
    step(1, 0, 32'h32, 0, 0, 0, 0, 0);
    step(1, 0, 32'h33, 0, 0, 0, 0, 0);
    step(1, 1, 32'hEEE, 0, 0, 0, 0, 0);
    chk("t5_wa0", ramWrAddr0_o, 3);
    chk("t5_pred_old", predRetAddr_o, 32'h33);
    idle();
    chk("t5_tos", ramRdAddr_o, 3);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_pred_new", predRetAddr_o, 32'hEEE);

    // Underflow pop, then reset while recovering
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t6_pv", predValid_o, 0);
    idle();
    chk("t6_tos", ramRdAddr_o, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6_rec_rst", ramRecover_o, 0);
    idle();
    chk("t6_busy", busy_o, 0);
    chk("t6_rec", ramRecover_o, 0);
    chk("t6_tos_end", ramRdAddr_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Pointer and control stage for the return address stack; sits directly upstream of the RAS storage RAM.
- Tracks a speculative top-of-stack (TOS) for fetch-time call/return prediction and an architectural TOS for retired calls/returns.
- Drives the RAM's read address, both write ports and its recover strobe.
- Sequences recovery so a retire-time push is never dropped, because the RAM ignores all writes in a recover cycle.

Parameters:
- DEPTH, 16, number of RAS entries.
- INDEX, 4, pointer width; log2(DEPTH).
- WIDTH, 32, return-address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- specPush_i  in  1  fetch predicts a call
- specPop_i  in  1  fetch predicts a return
- specPushAddr_i  in  WIDTH  return address to push (call PC + 8)
- archPush_i  in  1  call retired
- archPop_i  in  1  return retired
- archPushAddr_i  in  WIDTH  retired call's return address
- recoverFlag_i  in  1  pipeline flush (mispredict/exception), single-cycle pulse
- rasData_i  in  WIDTH  RAM read data (combinational from ramRdAddr_o)
- predRetAddr_o  out  WIDTH  predicted return address = rasData_i
- predValid_o  out  1  specCount != 0
- busy_o  out  1  high in RECOVER; fetch must stall
- ramRdAddr_o  out  INDEX  = specTos
- ramWrAddr0_o, ramWrData0_o, ramWe0_o  out  INDEX/WIDTH/1  speculative write port
- ramWrAddr1_o, ramWrData1_o, ramWe1_o  out  INDEX/WIDTH/1  architectural (checkpointed) write port
- ramRecover_o  out  1  RAM restore strobe

Behaviour:
- State: specTos, archTos (INDEX bits); specCount, archCount (INDEX+1 bits, 0..DEPTH); FSM {IDLE, RECOVER}.
- Reset: all pointers and counts 0; FSM IDLE. Outputs after reset: predValid_o=0, busy_o=0, all we=0, ramRecover_o=0, ramRdAddr_o=0.
- Pointer update rule (identical for spec and arch):
  - Push only: tos+1 mod DEPTH; write at the new tos; count+1, saturating at DEPTH. On overflow the oldest entry is silently overwritten.
  - Pop only with count>0: tos-1 mod DEPTH; count-1.
  - Pop only with count==0: no change (underflow ignored).
  - Push+pop together: tos unchanged; overwrite at tos; count unchanged, except count==0 becomes 1.
- Speculative port, IDLE only:
  - ramWe0_o = specPush_i.
  - ramWrAddr0_o = post-update specTos.
  - ramWrData0_o = specPushAddr_i.
- Architectural port, any state:
  - ramWe1_o = archPush_i, except in the ramRecover_o cycle (see below).
  - Address and data follow the same rule from archTos.
- Prediction: combinational, same cycle. predRetAddr_o reflects the TOS before this cycle's pop. A push in cycle N is visible to a pop in cycle N+1.
- FSM:
  - IDLE: recoverFlag_i -> RECOVER. Spec inputs in that cycle are ignored (no writes, no pointer change). Arch ops proceed.
  - RECOVER: busy_o=1; spec inputs ignored.
    - If archPush_i=1: perform the arch write, ramRecover_o=0, stay.
    - Else: ramRecover_o=1; specTos <= archTos_next; specCount <= archCount_next; -> IDLE. An archPop in this cycle still updates the arch pointer.
  - recoverFlag_i while in RECOVER: no additional effect.
- Latency: recovery completes at the earliest 1 cycle after recoverFlag_i. busy_o deasserts the cycle after ramRecover_o.
- ramRecover_o is registered-state derived and never coincides with ramWe1_o=1.
- Reset mid-RECOVER: return to IDLE with all pointers 0. No ramRecover_o is emitted.

Decomposition:
- Package ras_pkg:
  - RAS_DEPTH, RAS_INDEX constants.
  - typedef enum ras_state_t {RAS_IDLE, RAS_RECOVER}.
  - typedef struct ras_ptr_t {tos, count}.
- Sub-module ras_ptr_next (combinational): inputs ras_ptr_t, push, pop; outputs next ras_ptr_t and write index. Instantiated twice (spec, arch).

Test Plan:
- Reset then specPush A=0x100, B=0x200 on consecutive cycles -> ramWrAddr0_o=1 then 2. Next cycle specPop -> predRetAddr_o=0x200, predValid_o=1, specTos=1.
- 17 pushes, DEPTH=16 -> specCount saturates at 16, specTos wraps to 1, entry 1 overwritten. 17 pops -> last pop has predValid_o=0 and specTos unchanged.
- Spec push/push/pop while arch pushes one 0x100; recoverFlag_i -> next cycle ramRecover_o=1, specTos=archTos=1, specCount=1, busy_o high for 1 cycle.
- recoverFlag_i with archPush_i held 1 for 2 more cycles -> ramWe1_o=1 both cycles, ramRecover_o asserted only on the third cycle, spec copies the final archTos.
- Simultaneous specPush+specPop at specTos=3 -> ramWrAddr0_o=3, predRetAddr_o=old entry 3, specTos stays 3.
- Pop with count==0 -> no pointer change, predValid_o=0. Reset asserted during RECOVER -> IDLE, pointers 0, ramRecover_o never pulses.
